// File: rtl/apb_dec_pkg.sv
// apb_dec_pkg: shared state type and region-index helper for the APB region decoder.
package apb_dec_pkg;

   typedef enum logic [1:0] {IDLE, SETUP, ACCESS, ABORT} apb_dec_state_t;

   // Region index is the top sel_bits of an addr_w-bit address; the caller zero-extends into 64 bits.
   function automatic int unsigned region_idx(input logic [63:0] addr, input int unsigned addr_w,
                                              input int unsigned sel_bits);
      return 32'((addr >> (addr_w - sel_bits)) & ((64'd1 << sel_bits) - 64'd1));
   endfunction

endpackage

// File: rtl/apb_dec_watchdog.sv
// apb_dec_watchdog: saturating stall counter; expired_o flags the cycle whose increment reaches TIMEOUT.
module apb_dec_watchdog #(
   parameter int TIMEOUT = 16
) (
   input  logic clk,
   input  logic reset,
   input  logic clear_i,
   input  logic en_i,
   output logic expired_o
);

   localparam int CW = $clog2(TIMEOUT + 1);

   logic [CW-1:0] cnt_q, cnt_d;

   assign cnt_d = clear_i ? '0 : (en_i && cnt_q != CW'(TIMEOUT)) ? cnt_q + 1'b1 : cnt_q;
   assign expired_o = en_i && cnt_q >= CW'(TIMEOUT - 1);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) cnt_q <= '0;
      else cnt_q <= cnt_d;
   end

endmodule

// File: rtl/apb_region_decoder.sv
// apb_region_decoder: APB address decoder / response mux with an erroring default slave.
// Define APB_DEC_WATCHDOG_EN to compile in the stalled-slave watchdog and ABORT response.
module apb_region_decoder
   import apb_dec_pkg::*;
#(
   parameter int NUM_SLAVES = 3,
   parameter int ADDR_W     = 16,
   parameter int DATA_W     = 16,
   parameter int SEL_BITS   = 2,
   parameter int TIMEOUT    = 16
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         m_psel,
   input  logic                         m_penable,
   input  logic [ADDR_W-1:0]            m_paddr,
   output logic [DATA_W-1:0]            m_prdata,
   output logic                         m_pready,
   output logic                         m_pslverr,
   output logic [NUM_SLAVES-1:0]        s_psel,
   input  logic [NUM_SLAVES*DATA_W-1:0] s_prdata,
   input  logic [NUM_SLAVES-1:0]        s_pready
);

   apb_dec_state_t state_q, state_d, st;
   logic [SEL_BITS-1:0] idx_q, idx_d, dec_idx;
   logic [DATA_W-1:0] sel_rdata;
   logic sel_ready, sel_hit, wd_expired;

   if (NUM_SLAVES > 2**SEL_BITS) begin : g_chk_slaves
      $error("NUM_SLAVES exceeds 2**SEL_BITS");
   end
   if (TIMEOUT < 1) begin : g_chk_timeout
      $error("TIMEOUT must be at least 1");
   end

   assign dec_idx = SEL_BITS'(region_idx(64'(m_paddr), ADDR_W, SEL_BITS));
   // The master's setup cycle is recognised combinationally so s_psel needs no extra cycle.
   assign st = (state_q == IDLE && m_psel && !m_penable) ? SETUP : state_q;

`ifdef APB_DEC_WATCHDOG_EN
   apb_dec_watchdog #(.TIMEOUT(TIMEOUT)) u_wd (
      .clk      (clk),
      .reset    (reset),
      .clear_i  (st == SETUP),
      .en_i     (st == ACCESS && m_psel && sel_hit && !sel_ready),
      .expired_o(wd_expired)
   );
`else
   assign wd_expired = 1'b0;
`endif

   always_comb begin
      sel_hit = 1'b0;
      sel_rdata = '0;
      sel_ready = 1'b0;
      for (int i = 0; i < NUM_SLAVES; i++)
         if (SEL_BITS'(i) == idx_q) begin
            sel_hit = 1'b1;
            sel_rdata = s_prdata[i*DATA_W +: DATA_W];
            sel_ready = s_pready[i];
         end
   end

   // Outputs are forced low while reset is held so an asynchronous reset silences the bus at once.
   always_comb begin
      state_d = state_q;
      idx_d = idx_q;
      s_psel = '0;
      m_pready = 1'b0;
      m_pslverr = 1'b0;
      m_prdata = '0;
      if (!reset)
         case (st)
            SETUP: begin
               idx_d = dec_idx;
               state_d = ACCESS;
               for (int i = 0; i < NUM_SLAVES; i++) s_psel[i] = SEL_BITS'(i) == dec_idx;
            end
            ACCESS: begin
               if (!m_psel) state_d = IDLE;
               else if (!sel_hit) begin
                  m_pready = 1'b1;
                  m_pslverr = 1'b1;
                  state_d = IDLE;
               end else begin
                  for (int i = 0; i < NUM_SLAVES; i++) s_psel[i] = SEL_BITS'(i) == idx_q;
                  m_pready = sel_ready;
                  m_prdata = sel_ready ? sel_rdata : '0;
                  state_d = sel_ready ? IDLE : wd_expired ? ABORT : ACCESS;
               end
            end
`ifdef APB_DEC_WATCHDOG_EN
            ABORT: begin
               m_pready = 1'b1;
               m_pslverr = 1'b1;
               state_d = IDLE;
            end
`endif
            default: begin
               m_pready = m_penable;
               m_pslverr = m_penable;
            end
         endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         idx_q <= '0;
      end else begin
         state_q <= state_d;
         idx_q <= idx_d;
      end
   end

endmodule

// File: tb/tb_apb_region_decoder.sv
// tb_apb_region_decoder: directed and random APB transfers checked against a transfer-level model.
module tb_apb_region_decoder;

   localparam int NS = 3;
   localparam int TIMEOUT = 16;
`ifdef APB_DEC_WATCHDOG_EN
   localparam bit WD = 1'b1;
`else
   localparam bit WD = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset;
   logic m_psel, m_penable;
   logic [15:0] m_paddr;
   logic [15:0] m_prdata;
   logic m_pready, m_pslverr;
   logic [NS-1:0] s_psel;
   logic [NS*16-1:0] s_prdata;
   logic [NS-1:0] s_pready;
   int n_chk = 0;
   int n_fail = 0;

   apb_region_decoder #(
      .NUM_SLAVES(NS), .ADDR_W(16), .DATA_W(16), .SEL_BITS(2), .TIMEOUT(TIMEOUT)
   ) dut (
      .clk(clk), .reset(reset), .m_psel(m_psel), .m_penable(m_penable), .m_paddr(m_paddr),
      .m_prdata(m_prdata), .m_pready(m_pready), .m_pslverr(m_pslverr), .s_psel(s_psel),
      .s_prdata(s_prdata), .s_pready(s_pready)
   );

   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk_out(input string tag, input logic [2:0] sel, input logic rdy, input logic err,
                          input logic [15:0] data);
      chk({tag, ".s_psel"}, 32'(s_psel), 32'(sel));
      chk({tag, ".m_pready"}, 32'(m_pready), 32'(rdy));
      chk({tag, ".m_pslverr"}, 32'(m_pslverr), 32'(err));
      chk({tag, ".m_prdata"}, 32'(m_prdata), 32'(data));
   endtask

   task automatic drive_noise();
      s_pready = 3'($urandom);
      s_prdata = 48'({$urandom, $urandom});
   endtask

   task automatic idle_chk(input string tag);
      @(negedge clk);
      m_psel = 1'b0;
      m_penable = 1'b0;
      m_paddr = 16'($urandom);
      drive_noise();
      #2 chk_out(tag, 3'b000, 1'b0, 1'b0, 16'h0);
   endtask

   // Model: region = addr[15:14]; regions >= NS answer an error at once; a mapped slave that is
   // still stalled when TIMEOUT ACCESS cycles have elapsed is aborted on the following cycle.
   task automatic xfer(input logic [15:0] addr, input int waits, input logic [15:0] data);
      int idx, cyc;
      bit abort, done, rdy;
      logic [2:0] exp_sel;
      idx = int'(addr[15:14]);
      abort = WD && waits >= TIMEOUT;
      exp_sel = idx < NS ? 3'(1 << idx) : 3'b000;
      cyc = 0;
      done = 1'b0;
      @(negedge clk);
      m_psel = 1'b1;
      m_penable = 1'b0;
      m_paddr = addr;
      drive_noise();
      #2 chk_out("setup", exp_sel, 1'b0, 1'b0, 16'h0);
      while (!done) begin
         cyc++;
         @(negedge clk);
         m_penable = 1'b1;
         m_paddr = 16'($urandom);
         drive_noise();
         rdy = cyc > waits;
         if (idx < NS) begin
            s_pready[idx] = rdy;
            s_prdata[idx*16 +: 16] = data;
         end
         #2;
         if (idx >= NS) begin
            chk_out("unmapped", 3'b000, 1'b1, 1'b1, 16'h0);
            done = 1'b1;
         end else if (abort && cyc == TIMEOUT + 1) begin
            chk_out("abort", 3'b000, 1'b1, 1'b1, 16'h0);
            done = 1'b1;
         end else begin
            chk_out("access", exp_sel, rdy, 1'b0, rdy ? data : 16'h0);
            done = rdy;
         end
      end
   endtask

   initial begin
      reset = 1'b1;
      m_psel = 1'b1;
      m_penable = 1'b1;
      m_paddr = 16'h4000;
      s_pready = '1;
      s_prdata = '1;
      repeat (2) @(negedge clk);
      #2 chk_out("reset", 3'b000, 1'b0, 1'b0, 16'h0);
      @(negedge clk);
      reset = 1'b0;
      m_psel = 1'b0;
      m_penable = 1'b0;
      idle_chk("idle0");

      xfer(16'h4010, 0, 16'hBEEF);
      idle_chk("idle1");
      xfer(16'hC000, 0, 16'h1234);
      xfer(16'h8000, 200, 16'h5A5A);
      idle_chk("after_stall");
      xfer(16'h8000, TIMEOUT - 1, 16'hA1A1);
      xfer(16'h8000, TIMEOUT, 16'hB2B2);
      xfer(16'h4000, 100, 16'hC3C3);
      xfer(16'h0000, 3, 16'hD4D4);

      @(negedge clk);
      m_psel = 1'b1;
      m_penable = 1'b1;
      m_paddr = 16'h4000;
      s_pready = '1;
      #2 chk_out("proto_err", 3'b000, 1'b1, 1'b1, 16'h0);
      idle_chk("proto_idle");

      @(negedge clk);
      m_psel = 1'b1;
      m_penable = 1'b0;
      m_paddr = 16'h4000;
      s_pready = '0;
      #2 chk_out("drop_setup", 3'b010, 1'b0, 1'b0, 16'h0);
      @(negedge clk);
      m_penable = 1'b1;
      #2 chk_out("drop_access", 3'b010, 1'b0, 1'b0, 16'h0);
      @(negedge clk);
      m_psel = 1'b0;
      s_pready = '1;
      #2 chk_out("drop_psel", 3'b000, 1'b0, 1'b0, 16'h0);
      xfer(16'h4002, 1, 16'h0F0F);

      @(negedge clk);
      m_psel = 1'b1;
      m_penable = 1'b0;
      m_paddr = 16'h4000;
      s_pready = '0;
      #2 chk_out("rst_setup", 3'b010, 1'b0, 1'b0, 16'h0);
      repeat (3) begin
         @(negedge clk);
         m_penable = 1'b1;
         #2 chk_out("rst_stall", 3'b010, 1'b0, 1'b0, 16'h0);
      end
      #1 reset = 1'b1;
      #1 chk_out("rst_async", 3'b000, 1'b0, 1'b0, 16'h0);
      @(negedge clk);
      reset = 1'b0;
      m_psel = 1'b0;
      m_penable = 1'b0;
      xfer(16'h0004, 0, 16'h7E57);

      for (int t = 0; t < 40; t++) begin
         int w;
         w = ($urandom_range(0, 3) == 0) ? int'($urandom_range(TIMEOUT - 2, TIMEOUT + 2))
                                         : int'($urandom_range(0, 4));
         xfer(16'($urandom), w, 16'($urandom));
         if ($urandom_range(0, 1) == 1) idle_chk("rand_idle");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
